// File: rtl/ospfb_phasecomp.sv
// ospfb_phasecomp: phase-compensation stage between the polyphase FIR
// datapath and the FFT. Each frame of FFT_LEN filter sums is captured into
// one half of a ping-pong RAM and re-emitted circularly rotated by a per-frame
// shift that advances by (FFT_LEN - DEC_FAC) mod FFT_LEN every frame.
//
// Handshake: vin/vout are plain valid strobes. There is no ready signal on
// either side, so every vin=1 sample is accepted and every vout=1 sample must
// be consumed that cycle.
//
// Optional feature (macro OSPFB_PHASECOMP_BYPASS_EN): adds input `bypass`,
// sampled on the frame-completion cycle. A bypassed frame is emitted
// unrotated with shift_o=0, while the rotation schedule keeps advancing.
module ospfb_phasecomp #(
    parameter int WIDTH   = 16,
    parameter int FFT_LEN = 32,
    parameter int DEC_FAC = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vin,
    input  logic signed [WIDTH-1:0]     din,
`ifdef OSPFB_PHASECOMP_BYPASS_EN
    input  logic                        bypass,
`endif
    output logic                        vout,
    output logic signed [WIDTH-1:0]     dout,
    output logic                        vlast,
    output logic [$clog2(FFT_LEN)-1:0]  shift_o
);

    localparam int AW = $clog2(FFT_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);
    // Per-frame rotation increment; wraps naturally in AW bits since M is a power of two.
    localparam logic [AW-1:0] STEP = AW'(FFT_LEN - DEC_FAC);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // Ping-pong storage: address = {bank, index}.
    logic [WIDTH-1:0] mem [0:2*FFT_LEN-1];

    // Write side
    logic [AW-1:0] wr_idx;
    logic          wr_bank;
    logic [AW-1:0] next_shift;
    logic          frame_done;

    // Read side
    state_t        state;
    logic [AW-1:0] rd_idx;
    logic          rd_bank;
    logic [AW-1:0] frame_shift;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] apply_shift;

    // Read pipeline stage (aligned with the synchronous RAM output)
    logic [WIDTH-1:0] ram_q;
    logic             rd_v;
    logic             rd_last;
    logic [AW-1:0]    rd_shift;

    assign frame_done = vin && (wr_idx == LAST_IDX);
    assign rd_addr    = rd_idx + frame_shift;

`ifdef OSPFB_PHASECOMP_BYPASS_EN
    assign apply_shift = bypass ? '0 : next_shift;
`else
    assign apply_shift = next_shift;
`endif

    // Write pointer, bank select and rotation schedule.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx     <= '0;
            wr_bank    <= 1'b0;
            next_shift <= '0;
        end else if (vin) begin
            wr_idx <= wr_idx + 1'b1;
            if (frame_done) begin
                wr_bank    <= ~wr_bank;
                next_shift <= next_shift + STEP;
            end
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (vin && !rst) begin
            mem[{wr_bank, wr_idx}] <= din;
        end
    end

    // Read FSM: drains the completed bank starting at the frame's rotation offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_idx      <= '0;
            rd_bank     <= 1'b0;
            frame_shift <= '0;
            rd_v        <= 1'b0;
            rd_last     <= 1'b0;
            rd_shift    <= '0;
        end else begin
            rd_v     <= (state == READ);
            rd_last  <= (state == READ) && (rd_idx == LAST_IDX);
            rd_shift <= frame_shift;
            if (frame_done) begin
                // Completion takes priority so a frame ending on the last read
                // issue chains straight into the next frame with no bubble.
                state       <= READ;
                rd_idx      <= '0;
                rd_bank     <= wr_bank;
                frame_shift <= apply_shift;
            end else if (state == READ) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx == LAST_IDX) begin
                    state <= IDLE;
                end
            end
        end
    end

    // Synchronous RAM read port.
    always_ff @(posedge clk) begin
        ram_q <= mem[{rd_bank, rd_addr}];
    end

    // Output register: one cycle after the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vout    <= 1'b0;
            vlast   <= 1'b0;
            dout    <= '0;
            shift_o <= '0;
        end else begin
            vout  <= rd_v;
            vlast <= rd_last;
            if (rd_v) begin
                dout    <= $signed(ram_q);
                shift_o <= rd_shift;
            end
        end
    end

endmodule

// File: tb/tb_ospfb_phasecomp.sv
// tb_ospfb_phasecomp: directed plus randomized frames against a cycle-stamped
// reference model. Each completed input frame schedules M expected outputs at
// (completion edge + 2 + k) holding in_frame[(k + shift) mod M].
module tb_ospfb_phasecomp;

    localparam int WIDTH = 16;
    localparam int M     = 32;
    localparam int D     = 24;
    localparam int AW    = $clog2(M);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    vin;
    logic [WIDTH-1:0]        din;
    logic                    byp;
    logic                    vout;
    logic signed [WIDTH-1:0] dout;
    logic                    vlast;
    logic [AW-1:0]           shift_o;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] d;
        logic             l;
        logic [AW-1:0]    s;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] frame_buf[$];
    int               sched = 0;
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;
    bit               mon_en = 1'b0;
    bit               chk_rst = 1'b0;
    bit               chk_end = 1'b0;

    ospfb_phasecomp #(
        .WIDTH  (WIDTH),
        .FFT_LEN(M),
        .DEC_FAC(D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .vin    (vin),
        .din    (din),
`ifdef OSPFB_PHASECOMP_BYPASS_EN
        .bypass (byp),
`endif
        .vout   (vout),
        .dout   (dout),
        .vlast  (vlast),
        .shift_o(shift_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: collect frames, schedule rotated outputs.
    always @(posedge clk) begin
        int   s;
        exp_t e;
        cyc++;
        if (rst) begin
            frame_buf.delete();
            sched = 0;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= cyc)
                exp_q.pop_back();
        end else if (vin) begin
            frame_buf.push_back(din);
            if (frame_buf.size() == M) begin
                s = sched;
`ifdef OSPFB_PHASECOMP_BYPASS_EN
                if (byp) s = 0;
`endif
                for (int k = 0; k < M; k++) begin
                    e.cyc = cyc + 2 + k;
                    e.d   = frame_buf[(k + s) % M];
                    e.l   = (k == M - 1);
                    e.s   = AW'(s);
                    exp_q.push_back(e);
                end
                sched = (sched + M - D) % M;
                frame_buf.delete();
            end
        end
    end

    // Scoreboard: compare outputs away from the active edge.
    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        if (mon_en) begin
            ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            checks++;
            assert (vout === ev) else begin
                failures++;
                $error("FAIL vout cyc=%0d observed=%b expected=%b", cyc, vout, ev);
            end
            if (ev) begin
                e = exp_q.pop_front();
                checks++;
                assert ($unsigned(dout) === e.d) else begin
                    failures++;
                    $error("FAIL dout cyc=%0d observed=%0d expected=%0d", cyc, $unsigned(dout), e.d);
                end
                checks++;
                assert (vlast === e.l) else begin
                    failures++;
                    $error("FAIL vlast cyc=%0d observed=%b expected=%b", cyc, vlast, e.l);
                end
                checks++;
                assert (shift_o === e.s) else begin
                    failures++;
                    $error("FAIL shift_o cyc=%0d observed=%0d expected=%0d", cyc, shift_o, e.s);
                end
            end else begin
                checks++;
                assert (vlast === 1'b0) else begin
                    failures++;
                    $error("FAIL vlast_idle cyc=%0d observed=%b expected=0", cyc, vlast);
                end
            end
        end
        if (chk_rst) begin
            checks++;
            assert (dout === '0 && shift_o === '0 && vlast === 1'b0 && vout === 1'b0) else begin
                failures++;
                $error("FAIL reset_vals observed dout=%0d shift_o=%0d vlast=%b vout=%b expected all 0",
                       dout, shift_o, vlast, vout);
            end
        end
        if (chk_end) begin
            checks++;
            assert (exp_q.size() == 0) else begin
                failures++;
                $error("FAIL drain observed pending=%0d expected=0", exp_q.size());
            end
        end
    end

    // Driver tasks
    task automatic send(input logic [WIDTH-1:0] d);
        vin = 1'b1;
        din = d;
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        vin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Stimulus
    initial begin
        int cnt;
        int rpos;
        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        byp = 1'b0;
        @(posedge clk);
        #1;
        mon_en  = 1'b1;
        chk_rst = 1'b1;
        @(posedge clk);
        #1;
        chk_rst = 1'b0;
        rst     = 1'b0;

        // Frames 0..4 back-to-back, din = 100*n + k; bypass frame 1 when present.
        for (int n = 0; n < 5; n++) begin
            byp = (n == 1);
            for (int k = 0; k < M; k++) send(WIDTH'(100 * n + k));
        end
        byp = 1'b0;
        idle(40);

        // Frame fed with 1010... valid pattern.
        for (int k = 0; k < M; k++) begin
            send(WIDTH'(500 + k));
            idle(1);
        end
        idle(40);

        // Full frame, then reset 17 samples into the next one while output is in flight.
        for (int k = 0; k < M; k++) send(WIDTH'(650 + k));
        for (int k = 0; k < 17; k++) send(WIDTH'(600 + k));
        pulse_rst();
        for (int k = 0; k < M; k++) send(WIDTH'(700 + k));
        for (int k = 0; k < M; k++) send(WIDTH'(800 + k));
        idle(40);

        // Randomized frames with random gaps, random bypass and one random reset.
        rpos = int'($urandom_range(1, M - 2));
        for (int f = 0; f < 12; f++) begin
            byp = 1'($urandom_range(0, 1));
            cnt = 0;
            while (cnt < M) begin
                if (f == 6 && cnt == rpos) begin
                    pulse_rst();
                    rpos = -1;
                    cnt  = 0;
                end else if ($urandom_range(0, 3) != 0) begin
                    send(WIDTH'($urandom));
                    cnt++;
                end else begin
                    idle(1);
                end
            end
        end
        byp = 1'b0;
        idle(40);

        chk_end = 1'b1;
        @(posedge clk);
        #1;
        chk_end = 1'b0;
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
